// File: rtl/sram_bist_wrapper.sv
// Single-port synchronous SRAM with a March-style self-test engine and a
// registered sum/equality datapath on the two operand inputs.
module sram_bist_wrapper #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 9,
  // Qualification hook: when set, bit 0 of the cell at FAULT_ADDR is stuck at 0.
  parameter bit FAULT_EN   = 1'b0,
  parameter int FAULT_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csb0,
  input  logic              web0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic [DATA_W-1:0] dout0,
  output logic [DATA_W:0]   sum_q,
  output logic              equal_q,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] fail_addr
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] FAULT_A = FAULT_ADDR[ADDR_W-1:0];

  typedef enum logic [2:0] {S_IDLE, S_W0, S_R0W1, S_R1W0, S_RD0, S_DONE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] dout0_q;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic              tail_q, tail_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W:0]   sum_d;
  logic              equal_d;

  logic              mem_we, func_rd, bist_rd, chk_en;
  logic [ADDR_W-1:0] mem_waddr, chk_addr;
  logic [DATA_W-1:0] mem_wdata, mem_wdata_eff, chk_exp;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    tail_d      = tail_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    mem_we      = 1'b0;
    mem_waddr   = addr0;
    mem_wdata   = din0;
    func_rd     = 1'b0;
    bist_rd     = 1'b0;
    chk_en      = 1'b0;
    chk_addr    = addr_q;
    chk_exp     = '0;
    sum_d       = {1'b0, din0} + {1'b0, din1};
    equal_d     = (din0 == din1);

    case (state_q)
      S_IDLE, S_DONE: begin
        mem_we  = !csb0 && !web0;
        func_rd = !csb0 && web0;
        if (bist_start) begin
          state_d     = S_W0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          addr_d      = '0;
          phase_d     = 1'b0;
          tail_d      = 1'b0;
        end
      end
      S_W0: begin
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wdata = '0;
        addr_d    = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) state_d = S_R0W1;
      end
      S_R0W1: begin
        if (!phase_q) begin
          bist_rd = 1'b1;
          phase_d = 1'b1;
        end else begin
          chk_en    = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = '1;
          phase_d   = 1'b0;
          addr_d    = addr_q + 1'b1;
          if (addr_q == ADDR_MAX) begin
            state_d = S_R1W0;
            addr_d  = ADDR_MAX;
          end
        end
      end
      S_R1W0: begin
        chk_exp = '1;
        if (!phase_q) begin
          bist_rd = 1'b1;
          phase_d = 1'b1;
        end else begin
          chk_en    = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = '0;
          phase_d   = 1'b0;
          addr_d    = addr_q - 1'b1;
          if (addr_q == '0) begin
            state_d = S_RD0;
            addr_d  = '0;
          end
        end
      end
      S_RD0: begin
        // Pipelined: the compare for address a-1 overlaps the read of a.
        if (!tail_q) begin
          bist_rd = 1'b1;
          addr_d  = addr_q + 1'b1;
          if (addr_q == ADDR_MAX) tail_d = 1'b1;
        end
        if (addr_q != '0 || tail_q) begin
          chk_en   = 1'b1;
          chk_addr = addr_q - 1'b1;
        end
        if (tail_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (chk_en && rd_q != chk_exp && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = chk_addr;
    end
  end

  assign mem_wdata_eff = (FAULT_EN && mem_waddr == FAULT_A) ? {mem_wdata[DATA_W-1:1], 1'b0} : mem_wdata;

  // Array with registered reads; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata_eff;
    if (bist_rd) rd_q <= mem[addr_q];
    if (rst) dout0_q <= '0;
    else if (func_rd) dout0_q <= mem[addr0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      tail_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      sum_q       <= '0;
      equal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      tail_q      <= tail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      sum_q       <= sum_d;
      equal_q     <= equal_d;
    end
  end

  assign dout0     = dout0_q;
  assign bist_busy = busy_q;
  assign bist_done = done_q;
  assign bist_fail = fail_q;
  assign fail_addr = fail_addr_q;
endmodule

// File: tb/tb_sram_bist_wrapper.sv
// Bench for sram_bist_wrapper: a clean and a stuck-cell instance share stimulus
// and are compared each cycle against a March-algorithm reference model.
module tb_sram_bist_wrapper;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          csb0 = 1'b1, web0 = 1'b1, bist_start = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] din0 = '0, din1 = '0;

  logic [DW-1:0] dout0_o [2];
  logic [DW:0]   sum_o   [2];
  logic          equal_o [2];
  logic          busy_o  [2];
  logic          done_o  [2];
  logic          fail_o  [2];
  logic [AW-1:0] faddr_o [2];

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;
  int busy_cnt;

  always #5 clk = ~clk;

  sram_bist_wrapper #(.DATA_W(DW), .ADDR_W(AW)) dut_good (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .addr0(addr0),
    .din0(din0), .din1(din1), .dout0(dout0_o[0]), .sum_q(sum_o[0]),
    .equal_q(equal_o[0]), .bist_start(bist_start), .bist_busy(busy_o[0]),
    .bist_done(done_o[0]), .bist_fail(fail_o[0]), .fail_addr(faddr_o[0]));

  sram_bist_wrapper #(.DATA_W(DW), .ADDR_W(AW), .FAULT_EN(1'b1), .FAULT_ADDR(5)) dut_bad (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .addr0(addr0),
    .din0(din0), .din1(din1), .dout0(dout0_o[1]), .sum_q(sum_o[1]),
    .equal_q(equal_o[1]), .bist_start(bist_start), .bist_busy(busy_o[1]),
    .bist_done(done_o[1]), .bist_fail(fail_o[1]), .fail_addr(faddr_o[1]));

  // ---------------- reference model ----------------
  bit [DW-1:0] m_mem [2][D];
  bit [DW-1:0] m_dout [2];
  bit          m_fail [2];
  bit [AW-1:0] m_faddr [2];
  bit [DW:0]   m_sum;
  bit          m_eq, m_busy, m_done;
  int          m_t;

  function automatic void m_write(int k, int a, bit [DW-1:0] d);
    bit [DW-1:0] v = d;
    if (k == 1 && a == 5) v[0] = 1'b0;
    m_mem[k][a] = v;
  endfunction

  function automatic void m_check(int k, int a, bit [DW-1:0] e);
    if (m_mem[k][a] != e && !m_fail[k]) begin
      m_fail[k]  = 1'b1;
      m_faddr[k] = AW'(a);
    end
  endfunction

  // One BIST cycle, t counted from the first cycle after the start edge.
  function automatic void m_bist_step(int k, int t);
    int u;
    int a;
    if (t < D) begin
      m_write(k, t, 8'h00);
    end else if (t < 3 * D) begin
      u = t - D; a = u / 2;
      if (u % 2 == 1) begin m_check(k, a, 8'h00); m_write(k, a, 8'hFF); end
    end else if (t < 5 * D) begin
      u = t - 3 * D; a = D - 1 - u / 2;
      if (u % 2 == 1) begin m_check(k, a, 8'hFF); m_write(k, a, 8'h00); end
    end else begin
      u = t - 5 * D;
      if (u >= 1) m_check(k, u - 1, 8'h00);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_dout[k] = '0; m_fail[k] = 1'b0; m_faddr[k] = '0;
      end
      m_sum = '0; m_eq = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_t = 0;
    end else begin
      m_sum = (DW + 1)'(int'(din0) + int'(din1));
      m_eq  = (din0 == din1);
      if (!m_busy) begin
        for (int k = 0; k < 2; k++) begin
          if (!csb0 && !web0) m_write(k, int'(addr0), din0);
          else if (!csb0) m_dout[k] = m_mem[k][addr0];
        end
        if (bist_start) begin
          m_busy = 1'b1; m_done = 1'b0; m_t = 0;
          for (int k = 0; k < 2; k++) begin m_fail[k] = 1'b0; m_faddr[k] = '0; end
        end
      end else begin
        for (int k = 0; k < 2; k++) m_bist_step(k, m_t);
        m_t++;
        if (m_t == 6 * D + 1) begin m_busy = 1'b0; m_done = 1'b1; end
      end
    end
  end

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] at %0t: got=%0h want=%0h", nm, k, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("dout0", k, 32'(dout0_o[k]), 32'(m_dout[k]));
        chk("sum_q", k, 32'(sum_o[k]), 32'(m_sum));
        chk("equal_q", k, 32'(equal_o[k]), 32'(m_eq));
        chk("bist_busy", k, 32'(busy_o[k]), 32'(m_busy));
        chk("bist_done", k, 32'(done_o[k]), 32'(m_done));
        chk("bist_fail", k, 32'(fail_o[k]), 32'(m_fail[k]));
        chk("fail_addr", k, 32'(faddr_o[k]), 32'(m_faddr[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_inputs(bit allow_start);
    csb0       = 1'($urandom_range(0, 1));
    web0       = 1'($urandom_range(0, 1));
    addr0      = AW'($urandom_range(0, D - 1));
    din0       = DW'($urandom);
    din1       = ($urandom_range(0, 3) == 0) ? din0 : DW'($urandom);
    bist_start = allow_start && ($urandom_range(0, 7) == 0);
  endtask

  task automatic idle_inputs();
    csb0 = 1'b1; web0 = 1'b1; bist_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs.
    rst = 1'b1;
    rand_inputs(1'b1);
    cyc();
    check_en = 1'b1;
    rand_inputs(1'b1);
    cyc();
    $display("phase reset");
    chk("rst_dout0", 0, 32'(dout0_o[0]), 32'h0);
    chk("rst_sum", 0, 32'(sum_o[0]), 32'h0);
    chk("rst_busy", 0, 32'(busy_o[0]), 32'h0);
    chk("rst_faddr", 1, 32'(faddr_o[1]), 32'h0);
    rst = 1'b0;

    // Fill the array so every later read has a defined value.
    for (int a = 0; a < D; a++) begin
      csb0 = 1'b0; web0 = 1'b0; addr0 = AW'(a); din0 = DW'($urandom); din1 = DW'($urandom);
      bist_start = 1'b0;
      cyc();
    end

    for (int i = 0; i < 150; i++) begin
      rand_inputs(1'b0);
      cyc();
    end

    $display("phase functional write/read");
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'hF; din0 = 8'hA5; cyc();
    web0 = 1'b1; cyc();
    chk("rd_A5", 0, 32'(dout0_o[0]), 32'hA5);
    csb0 = 1'b1; addr0 = 4'h2; cyc();
    chk("hold_A5", 0, 32'(dout0_o[0]), 32'hA5);

    $display("phase datapath");
    din0 = 8'hFF; din1 = 8'h01; cyc();
    chk("sum_100", 0, 32'(sum_o[0]), 32'h100);
    chk("eq_0", 0, 32'(equal_o[0]), 32'h0);
    din0 = 8'h3C; din1 = 8'h3C; cyc();
    chk("sum_078", 0, 32'(sum_o[0]), 32'h078);
    chk("eq_1", 0, 32'(equal_o[0]), 32'h1);

    $display("phase bist full run");
    idle_inputs(); bist_start = 1'b1; cyc();
    bist_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 300 && busy_o[0] === 1'b1; i++) begin
      busy_cnt++;
      rand_inputs(1'b1);
      if (i == 10 || i == 85) begin csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3; din0 = 8'h77; end
      cyc();
    end
    idle_inputs();
    chk("busy_cycles", 0, 32'(busy_cnt), 32'd97);
    chk("done_good", 0, 32'(done_o[0]), 32'h1);
    chk("fail_good", 0, 32'(fail_o[0]), 32'h0);
    chk("done_bad", 1, 32'(done_o[1]), 32'h1);
    chk("fail_bad", 1, 32'(fail_o[1]), 32'h1);
    chk("faddr_bad", 1, 32'(faddr_o[1]), 32'h5);

    $display("phase post-bist readback");
    for (int a = 0; a < D; a++) begin
      csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(a); cyc();
      chk("post_bist_rd", 0, 32'(dout0_o[0]), 32'h0);
      chk("post_bist_rd", 1, 32'(dout0_o[1]), 32'h0);
    end

    $display("phase bist abort");
    idle_inputs(); bist_start = 1'b1; cyc();
    bist_start = 1'b0;
    for (int i = 0; i < 39; i++) begin
      rand_inputs(1'b1);
      cyc();
    end
    idle_inputs(); rst = 1'b1; cyc();
    chk("abort_busy", 0, 32'(busy_o[0]), 32'h0);
    chk("abort_done", 0, 32'(done_o[0]), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rand_inputs(1'b0);
      cyc();
    end
    idle_inputs(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_bist_wrapper.md
Name: sram_bist_wrapper

Overview:
Parametrised single-port synchronous SRAM wrapper with an integrated March-style BIST engine and a registered dual-operand datapath (sum plus equality). It succeeds the fixed 8x512 RAM-only test block. It generalises width and depth, keeps the adder carry, registers the compare, and adds self-test. It sits between the test harness/pads and the SRAM array. The array is a behavioural model with macro-compatible timing: one-cycle read latency, write-through disabled.

Parameters:
DATA_W, 8, data width of array, din0/din1, dout0
ADDR_W, 9, address width; array depth DEPTH = 2**ADDR_W

Ports:
clk  in  1  single clock
rst  in  1  reset; one clock; reset is synchronous and active-high
csb0  in  1  active-low chip select, functional port
web0  in  1  active-low write enable, functional port
addr0  in  ADDR_W  functional address
din0  in  DATA_W  write data / operand A
din1  in  DATA_W  operand B
dout0  out  DATA_W  read data
sum_q  out  DATA_W+1  registered din0+din1, carry kept
equal_q  out  1  registered (din0==din1)
bist_start  in  1  pulse; starts BIST when idle
bist_busy  out  1  BIST running
bist_done  out  1  sticky; BIST finished
bist_fail  out  1  sticky; at least one miscompare
fail_addr  out  ADDR_W  address of first miscompare

Behaviour:
- Reset (rst high at clk edge) clears dout0, sum_q, equal_q, bist_busy, bist_done, bist_fail and fail_addr to 0, and forces the FSM to IDLE. Array contents are not reset.
- Datapath: every cycle, sum_q <= zero-extended din0 + din1, and equal_q <= (din0==din1). Latency is 1 cycle, independent of csb0 and BIST.
- Functional port (FSM in IDLE or DONE only):
  - csb0=0, web0=0: mem[addr0] <= din0.
  - csb0=0, web0=1: dout0 <= mem[addr0] on the next edge (1-cycle latency).
  - csb0=1: dout0 holds its value.
  - No read-during-write forwarding is needed; a read and a write cannot occur in the same cycle.
- While bist_busy=1, csb0/web0/addr0 are ignored, the array is driven only by BIST, and dout0 holds its value.
- FSM states: IDLE, W0, R0W1, R1W0, RD0, DONE.
  - IDLE/DONE + bist_start=1 -> W0. The same edge clears bist_done, bist_fail and fail_addr, and sets bist_busy=1.
  - bist_start is ignored while busy.
  - W0, ascending: write all-zeros, 1 address/cycle, DEPTH cycles.
  - R0W1, ascending: 2 cycles/address. Cycle A reads. Cycle B compares the returned data with all-zeros, then writes all-ones. 2*DEPTH cycles.
  - R1W0, descending: same as R0W1, but expects all-ones and writes all-zeros. 2*DEPTH cycles.
  - RD0, ascending: read with expect all-zeros, pipelined 1 address/cycle; the last compare lands 1 cycle after the last read. DEPTH+1 cycles.
  - Then DONE: bist_busy=0, bist_done=1.
  - Total time from the start edge to bist_done high is 6*DEPTH+1 cycles.
- Miscompare: on the first one, set bist_fail=1 and fail_addr=address read. Later miscompares do not update fail_addr. The test runs to completion regardless of failures.
- Address counters wrap at DEPTH-1 (ascending) and at 0 (descending), and the FSM advances on the wrap.
- Reset mid-BIST aborts to IDLE with all flags cleared. The array is left in a partial pattern.
- After BIST completes, the array is all-zeros on a good part.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs -> dout0=0, sum_q=0, equal_q=0, all bist_* = 0, fail_addr=0.
- Functional write/read: write 0xA5 to addr 0x1FF, then read 0x1FF -> dout0=0xA5 exactly 1 cycle after the read edge. With csb0=1, dout0 holds 0xA5.
- Datapath: din0=0xFF, din1=0x01 -> next cycle sum_q=0x100, equal_q=0. Then din0=din1=0x3C -> sum_q=0x078, equal_q=1.
- Clean BIST with ADDR_W=4 (DEPTH=16): pulse bist_start -> bist_busy=1 for 97 cycles, bist_done=1, bist_fail=0. Reading any address afterwards returns 0x00.
- Fault BIST with ADDR_W=4: force bit 0 of array entry 5 to 0 for the whole run -> bist_fail=1 and fail_addr=5 (first miscompare, in R1W0). bist_done still asserts at cycle 97.
- Interference and abort: issue a write to addr 3 with data 0x77 during BIST -> ignored, and addr 3 reads 0x00 afterwards. A second bist_start while busy has no effect. Asserting rst at cycle 40 -> IDLE next edge, bist_busy=0, bist_done=0.
